// File: rtl/seg7_scanner_if.sv
// -----------------------------------------------------------------------------
// seg7_scanner_if
// Bundle between the display register block (master) and the seven-segment
// scanner (slave).
//
// Signals:
//   value       [31:0] hex value, digit i = value[4i+3:4i], digit 0 rightmost
//   mask        [7:0]  digit enable, bit i = digit i, 1 = shown
//   error              request to show "Err" instead of the value
//   frame_start        one-cycle strobe, first BLANK cycle of digit 0
//   anodes      [7:0]  active-low digit select
//   cathodes    [7:0]  active-low segments {dp,g,f,e,d,c,b,a}
//   dbg_state          scanner slot state (0 = BLANK, 1 = DRIVE)
//
// Transfer rule (the only handshake on this bus): there is no valid/ready
// pair and no backpressure. The master keeps value/mask/error stable while
// frame_start is high; the slave samples them on the clock edge that ends the
// frame_start cycle. Changes at any other time are ignored until the next
// frame_start.
// -----------------------------------------------------------------------------
interface seg7_scanner_if;
  logic [31:0] value;
  logic [7:0]  mask;
  logic        error;
  logic        frame_start;
  logic [7:0]  anodes;
  logic [7:0]  cathodes;
  logic        dbg_state;

  modport master (
    output value,
    output mask,
    output error,
    input  frame_start,
    input  anodes,
    input  cathodes,
    input  dbg_state
  );

  modport slave (
    input  value,
    input  mask,
    input  error,
    output frame_start,
    output anodes,
    output cathodes,
    output dbg_state
  );
endinterface

// File: rtl/seg7_scanner.sv
// -----------------------------------------------------------------------------
// seg7_scanner
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each frame snapshots value/mask/error, then visits digits 0..7, one slot of
// TICK_DIV cycles each. The first BLANK_CYCLES cycles of every slot keep all
// anodes off to avoid ghosting; the rest of the slot drives the digit.
// In error mode the display shows "Err" on digits 2..0.
//
// Parameters:
//   TICK_DIV      clk cycles per digit slot, >= BLANK_CYCLES+1
//   BLANK_CYCLES  blank cycles at the start of each slot, >= 1
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    seg7_scanner_if.slave (value, mask, error in;
//          frame_start, anodes, cathodes, dbg_state out)
//
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN
//   defined   -> leading zeros among enabled digits are blanked (non-error
//                mode only); digit 0 is never blanked.
//   undefined -> every enabled digit is shown, leading zeros included.
// -----------------------------------------------------------------------------
module seg7_scanner #(
  parameter int TICK_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset,
  seg7_scanner_if.slave bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  // Slot state
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  // Fixed glyphs for error mode
  localparam logic [7:0] SEG_E   = 8'h86;
  localparam logic [7:0] SEG_R   = 8'hAF;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [0:0]    r_state;
  // Low for the first clock after reset so that frame_start is never seen in
  // a cycle that directly follows a reset edge; the scan starts one clock
  // after reset is released.
  logic          r_armed;

  logic [31:0]   r_value;
  logic [7:0]    r_mask;
  logic          r_error;

  logic [7:0]    r_anodes;
  logic [7:0]    r_cathodes;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic          w_frame_start;
  logic [3:0]    w_nib [8];
  logic [7:0]    w_code [8];
  logic [7:0]    w_digit_en;
  logic [7:0]    w_lz_suppress;
  logic [7:0]    w_an_next;
  logic [7:0]    w_ca_next;

  // ---------------------------------------------------------------------------
  // Hex digit to active-low segment byte {dp,g,f,e,d,c,b,a}, dp off
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] hex_to_seg(input logic [3:0] d);
    logic [7:0] seg;
    case (d)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Frame starts in the first BLANK cycle of digit 0 once the scan is running
  assign w_frame_start = r_armed && (r_cnt == '0) && (r_idx == 3'd0);

  // ---------------------------------------------------------------------------
  // Slot counter, digit index, slot state, snapshot and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_idx      <= 3'd0;
      r_state    <= ST_BLANK;
      r_armed    <= 1'b0;
      r_value    <= 32'h0;
      r_mask     <= 8'h00;
      r_error    <= 1'b0;
      r_anodes   <= SEG_OFF;
      r_cathodes <= SEG_OFF;
    end else begin
      r_armed <= 1'b1;

      if (r_armed) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_idx   <= r_idx + 3'd1;
          r_state <= ST_BLANK;
        end else begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == BLANK_LAST) begin
            r_state <= ST_DRIVE;
          end
        end
      end

      if (w_frame_start) begin
        r_value <= bus.value;
        r_mask  <= bus.mask;
        r_error <= bus.error;
      end

      // Outputs follow the current slot position with one cycle of latency
      r_anodes   <= w_an_next;
      r_cathodes <= w_ca_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Split the snapshot into digits
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_nib[i] = r_value[4*i +: 4];
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero suppression
  // ---------------------------------------------------------------------------
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic w_lz_seen;

  // Walk from the top digit down. An enabled zero digit is blanked until the
  // first enabled nonzero digit has been passed. Digit 0 is not visited, so
  // it is never blanked by this logic.
  always_comb begin
    w_lz_suppress = 8'h00;
    w_lz_seen     = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (r_mask[i]) begin
        if (w_nib[i] != 4'h0) begin
          w_lz_seen = 1'b1;
        end else if (!w_lz_seen) begin
          w_lz_suppress[i] = 1'b1;
        end
      end
    end
  end
`else
  assign w_lz_suppress = 8'h00;
`endif

  // ---------------------------------------------------------------------------
  // Per-digit enable and glyph. Error mode ignores the mask entirely.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (r_error) begin
        w_digit_en[i] = (i < 3);
        w_code[i]     = (i == 2) ? SEG_E : SEG_R;
      end else begin
        w_digit_en[i] = r_mask[i] & ~w_lz_suppress[i];
        w_code[i]     = hex_to_seg(w_nib[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next output values for the current slot position
  // ---------------------------------------------------------------------------
  always_comb begin
    w_an_next = SEG_OFF;
    w_ca_next = SEG_OFF;
    if ((r_state == ST_DRIVE) && w_digit_en[r_idx]) begin
      w_an_next = ~(8'b1 << r_idx);
      w_ca_next = w_code[r_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.frame_start = w_frame_start;
  assign bus.anodes      = r_anodes;
  assign bus.cathodes    = r_cathodes;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_seg7_scanner.sv
// -----------------------------------------------------------------------------
// tb_seg7_scanner
// Directed bench for seg7_scanner with TICK_DIV=10, BLANK_CYCLES=2.
// Position inside a frame is tracked as an offset from the frame_start cycle;
// slot k covers offsets 10k..10k+9 and, because the outputs are registered,
// its visible DRIVE window is offsets 10k+3..10k+10. Blank samples are taken
// at 10k+1 and 10k+2, drive samples at 10k+6.
// -----------------------------------------------------------------------------
module tb_seg7_scanner;

  localparam int TD = 10;
  localparam int BC = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seg7_scanner_if bus ();

  seg7_scanner #(
    .TICK_DIV     (TD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int err_cnt = 0;
  int chk_cnt = 0;
  int pos     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step_to(input int tgt);
    while (pos < tgt) begin
      @(negedge clk);
      pos++;
    end
  endtask

  task automatic goto_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.frame_start !== 1'b1 && n < 200);
    chk("frame_start_seen", {31'b0, bus.frame_start}, 32'd1);
    pos = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0]     value;
    logic [7:0]      mask;
    logic            error;
    logic [7:0][7:0] an;       // byte k = expected anodes in slot k
    logic [7:0][7:0] ca;       // byte k = expected cathodes in slot k
    int              chg_slot; // slot whose blank phase changes value, -1 none
    logic [31:0]     chg_val;
  } vec_t;

  localparam logic [63:0] AN_ALL = {8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
  localparam int NV = 11;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] v, input logic [7:0] m, input logic e,
                              input logic [63:0] an, input logic [63:0] ca,
                              input int cs, input logic [31:0] cv);
    vec_t r;
    r.value    = v;
    r.mask     = m;
    r.error    = e;
    r.an       = an;
    r.ca       = ca;
    r.chg_slot = cs;
    r.chg_val  = cv;
    return r;
  endfunction

  task automatic run_frame(input int id, input vec_t v);
    bus.value = v.value;
    bus.mask  = v.mask;
    bus.error = v.error;
    goto_frame();
    for (int k = 0; k < 8; k++) begin
      step_to(k*TD + 1);
      if (k == v.chg_slot) bus.value = v.chg_val;
      if (k == 0) chk($sformatf("v%0d state_blank", id), {31'b0, bus.dbg_state}, 32'd0);
      chk($sformatf("v%0d s%0d blank1 an", id, k), {24'b0, bus.anodes},   32'hFF);
      chk($sformatf("v%0d s%0d blank1 ca", id, k), {24'b0, bus.cathodes}, 32'hFF);
      step_to(k*TD + 2);
      chk($sformatf("v%0d s%0d blank2 an", id, k), {24'b0, bus.anodes},   32'hFF);
      chk($sformatf("v%0d s%0d blank2 ca", id, k), {24'b0, bus.cathodes}, 32'hFF);
      step_to(k*TD + 6);
      if (k == 0) chk($sformatf("v%0d state_drive", id), {31'b0, bus.dbg_state}, 32'd1);
      chk($sformatf("v%0d s%0d an", id, k), {24'b0, bus.anodes},   {24'b0, v.an[k]});
      chk($sformatf("v%0d s%0d ca", id, k), {24'b0, bus.cathodes}, {24'b0, v.ca[k]});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    vecs[0] = mk(32'h000012AB, 8'hFF, 1'b0,
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'h88, 8'h83}, -1, 32'h0);
    vecs[8] = mk(32'h000000A0, 8'hFF, 1'b0,
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 8'hFE},
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h88, 8'hC0}, -1, 32'h0);
    vecs[9] = mk(32'h00000000, 8'hFF, 1'b0,
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE},
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, -1, 32'h0);
`else
    vecs[0] = mk(32'h000012AB, 8'hFF, 1'b0, AN_ALL,
                 {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hA4, 8'h88, 8'h83}, -1, 32'h0);
    vecs[8] = mk(32'h000000A0, 8'hFF, 1'b0, AN_ALL,
                 {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h88, 8'hC0}, -1, 32'h0);
    vecs[9] = mk(32'h00000000, 8'hFF, 1'b0, AN_ALL, {8{8'hC0}}, -1, 32'h0);
`endif
    vecs[1] = mk(32'h89ABCDEF, 8'h0F, 1'b0,
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF7, 8'hFB, 8'hFD, 8'hFE},
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC6, 8'hA1, 8'h86, 8'h8E}, -1, 32'h0);
    vecs[2] = mk(32'h12345678, 8'hFF, 1'b1,
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFD, 8'hFE},
                 {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h86, 8'hAF, 8'hAF}, -1, 32'h0);
    vecs[3] = mk(32'h76543210, 8'hFF, 1'b0, AN_ALL,
                 {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}, -1, 32'h0);
    vecs[4] = mk(32'hFEDCBA98, 8'hFF, 1'b0, AN_ALL,
                 {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80}, -1, 32'h0);
    vecs[5] = mk(32'h90000000, 8'hA5, 1'b0,
                 {8'h7F, 8'hFF, 8'hDF, 8'hFF, 8'hFF, 8'hFB, 8'hFF, 8'hFE},
                 {8'h90, 8'hFF, 8'hC0, 8'hFF, 8'hFF, 8'hC0, 8'hFF, 8'hC0}, -1, 32'h0);
    // Value changes in slot 3 of this frame; the snapshot must hold
    vecs[6] = mk(32'h11111111, 8'hFF, 1'b0, AN_ALL, {8{8'hF9}}, 3, 32'h22222222);
    vecs[7] = mk(32'h22222222, 8'hFF, 1'b0, AN_ALL, {8{8'hA4}}, -1, 32'h0);
    // Error mode with an empty mask: mask is ignored
    vecs[10] = mk(32'h00000000, 8'h00, 1'b1,
                  {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFB, 8'hFD, 8'hFE},
                  {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h86, 8'hAF, 8'hAF}, -1, 32'h0);

    // Reset held for 5 cycles
    reset     = 1'b1;
    bus.value = 32'h0;
    bus.mask  = 8'h00;
    bus.error = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset an",    {24'b0, bus.anodes},      32'hFF);
    chk("reset ca",    {24'b0, bus.cathodes},    32'hFF);
    chk("reset fs",    {31'b0, bus.frame_start}, 32'd0);
    chk("reset state", {31'b0, bus.dbg_state},   32'd0);

    // Release: frame_start in the first cycle after, then every 8*TD cycles
    reset = 1'b0;
    @(negedge clk);
    chk("fs after release", {31'b0, bus.frame_start}, 32'd1);
    @(negedge clk);
    chk("fs one cycle", {31'b0, bus.frame_start}, 32'd0);
    n = 1;
    while (bus.frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("frame period", n, 32'(8*TD));

    // Table-driven frames
    for (int i = 0; i < NV; i++) begin
      run_frame(i, vecs[i]);
    end

    // Reset in the middle of slot 5
    bus.value = 32'h0;
    bus.mask  = 8'hFF;
    bus.error = 1'b0;
    goto_frame();
    step_to(5*TD + 6);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset an", {24'b0, bus.anodes},      32'hFF);
    chk("midreset ca", {24'b0, bus.cathodes},    32'hFF);
    chk("midreset fs", {31'b0, bus.frame_start}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("fs after midreset", {31'b0, bus.frame_start}, 32'd1);
    pos = 0;
    step_to(6);
    chk("post-reset s0 an", {24'b0, bus.anodes},   32'hFE);
    chk("post-reset s0 ca", {24'b0, bus.cathodes}, 32'hC0);
    step_to(TD + 6);
    chk("post-reset s1 an", {24'b0, bus.anodes},   32'h000000FF & 32'(
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      8'hFF
`else
      8'hFD
`endif
    ));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
